// File: rtl/gdr_pkt_pkg.sv
// Shared packet-path definitions for the RX checker pool and its lane scheduler.
package gdr_pkt_pkg;

   localparam int NO_OF_RCHK      = 4;
   localparam int NO_OF_RCHK_ADDR = $clog2(NO_OF_RCHK);
   localparam int DEF_TIMEOUT_CYC = 4096;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DROP   = 2'd2
   } SCHED_STATE_e;

endpackage

// File: rtl/rr_free_pick.sv
// Round-robin first-free finder: returns the first non-busy lane after i_ptr, wrapping.
module rr_free_pick #(
   parameter int N  = 4,
   parameter int AW = $clog2(N)
) (
   input  logic [N-1:0]  i_busy,
   input  logic [AW-1:0] i_ptr,
   output logic          o_found,
   output logic [AW-1:0] o_idx
);

   always_comb begin
      int w_lane;
      w_lane  = 0;
      o_found = 1'b0;
      o_idx   = '0;
      // ptr itself is searched last, so the most recent grantee has lowest priority
      for (int k = 1; k <= N; k++) begin
         w_lane = (int'(i_ptr) + k) % N;
         if (!o_found && !i_busy[AW'(w_lane)]) begin
            o_found = 1'b1;
            o_idx   = AW'(w_lane);
         end
      end
   end

endmodule

// File: rtl/rchk_lane_sched.sv
// Steers RX PCS packets onto a pool of packet checkers: round-robin grant on SOP,
// ownership until TERM, lane held busy until the checker reports done.
//
//  state  | meaning
//  IDLE   | no packet open; SOP may be granted, dropped or ignored
//  ACTIVE | packet open on lane r_cur; beats strobed to that lane
//  DROP   | packet open with no lane; beats swallowed until TERM or timeout
module rchk_lane_sched #(
   parameter int NO_OF_RCHK      = gdr_pkt_pkg::NO_OF_RCHK,
   parameter int NO_OF_RCHK_ADDR = $clog2(NO_OF_RCHK),
   parameter int TIMEOUT_CYC     = gdr_pkt_pkg::DEF_TIMEOUT_CYC,
   parameter int CNT_WD          = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_en,
   input  logic                       rx_pcs_vld,
   input  logic                       rx_pcs_sop_det,
   input  logic                       rx_pcs_term_det,
   input  logic [NO_OF_RCHK-1:0]      rchk_done,
   output logic [NO_OF_RCHK-1:0]      rchk_pkt_vld,
   output logic [NO_OF_RCHK-1:0]      rchk_sop,
   output logic [NO_OF_RCHK-1:0]      rchk_term,
   output logic [NO_OF_RCHK_ADDR-1:0] rchk_ln_id,
   output logic [NO_OF_RCHK-1:0]      sched_busy_mask,
   output logic [CNT_WD-1:0]          sched_drop_cnt,
   output logic [CNT_WD-1:0]          sched_timeout_cnt,
   output logic [CNT_WD-1:0]          sched_orphan_cnt
);
   import gdr_pkt_pkg::*;

   localparam int             TO_WD   = $clog2(TIMEOUT_CYC);
   localparam logic [TO_WD-1:0] TO_LOAD = TO_WD'(TIMEOUT_CYC - 1);

   SCHED_STATE_e               r_state;
   logic [NO_OF_RCHK_ADDR-1:0] r_cur;
   logic [NO_OF_RCHK_ADDR-1:0] r_ptr;
   logic [NO_OF_RCHK-1:0]      r_busy;
   logic [TO_WD-1:0]           r_to_cnt;
   logic [CNT_WD-1:0]          r_drop_cnt;
   logic [CNT_WD-1:0]          r_timeout_cnt;
   logic [CNT_WD-1:0]          r_orphan_cnt;

   logic                       w_found;
   logic [NO_OF_RCHK_ADDR-1:0] w_idx;
   logic                       w_in_pkt;
   logic                       w_sop_new;
   logic                       w_new_term;
   logic                       w_grant;
   logic                       w_drop;
   logic                       w_open_new;
   logic                       w_orphan;
   logic                       w_to_hit;
   logic [NO_OF_RCHK-1:0]      w_grant_oh;
   logic [NO_OF_RCHK-1:0]      w_to_oh;

   function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   rr_free_pick #(
      .N  (NO_OF_RCHK),
      .AW (NO_OF_RCHK_ADDR)
   ) u_pick (
      .i_busy  (r_busy),
      .i_ptr   (r_ptr),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   // An SOP starts a new packet from IDLE, or right behind a TERM that closes the open one.
   assign w_in_pkt   = (r_state == ACTIVE) || (r_state == DROP);
   assign w_sop_new  = rx_pcs_vld && rx_pcs_sop_det && ((r_state == IDLE) || rx_pcs_term_det);
   assign w_new_term = (r_state == IDLE) && rx_pcs_term_det;
   assign w_grant    = w_sop_new && cfg_en && w_found;
   assign w_drop     = w_sop_new && cfg_en && !w_found;
   assign w_open_new = (w_grant || w_drop) && !w_new_term;
   assign w_orphan   = rx_pcs_vld && (r_state == IDLE) && rx_pcs_term_det && !rx_pcs_sop_det;
   assign w_to_hit   = rx_pcs_vld && w_in_pkt && !rx_pcs_term_det && !rx_pcs_sop_det &&
                       (r_to_cnt == '0);
   assign w_grant_oh = w_grant ? (NO_OF_RCHK'(1) << w_idx) : '0;
   assign w_to_oh    = (w_to_hit && (r_state == ACTIVE)) ? (NO_OF_RCHK'(1) << r_cur) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cur         <= '0;
         r_ptr         <= '0;
         r_busy        <= '0;
         r_to_cnt      <= '0;
         r_drop_cnt    <= '0;
         r_timeout_cnt <= '0;
         r_orphan_cnt  <= '0;
         rchk_pkt_vld  <= '0;
         rchk_sop      <= '0;
         rchk_term     <= '0;
         rchk_ln_id    <= '0;
      end else begin
         rchk_pkt_vld <= w_grant_oh;
         rchk_sop     <= w_grant_oh;
         rchk_term    <= '0;
         // a same-cycle grant beats a done on that lane
         r_busy       <= (r_busy & ~rchk_done & ~w_to_oh) | w_grant_oh;

         if (w_grant) begin
            r_ptr      <= w_idx;
            rchk_ln_id <= w_idx;
         end
         if (w_drop)   r_drop_cnt    <= sat_inc(r_drop_cnt);
         if (w_to_hit) r_timeout_cnt <= sat_inc(r_timeout_cnt);
         if (w_orphan) r_orphan_cnt  <= sat_inc(r_orphan_cnt);

         case (r_state)
            IDLE: begin
               if (w_grant && rx_pcs_term_det) rchk_term[w_idx] <= 1'b1;
            end
            ACTIVE, DROP: begin
               if (rx_pcs_vld) begin
                  if (rx_pcs_term_det) begin
                     if (r_state == ACTIVE) begin
                        rchk_pkt_vld[r_cur] <= 1'b1;
                        rchk_term[r_cur]    <= 1'b1;
                     end
                     r_state <= IDLE;
                  end else if (rx_pcs_sop_det) begin
                     if (r_state == ACTIVE) begin
                        rchk_pkt_vld[r_cur] <= 1'b1;
                        rchk_sop[r_cur]     <= 1'b1;
                     end
                     r_to_cnt <= TO_LOAD;
                  end else if (w_to_hit) begin
                     r_state <= IDLE;
                  end else begin
                     if (r_state == ACTIVE) rchk_pkt_vld[r_cur] <= 1'b1;
                     r_to_cnt <= r_to_cnt - 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_open_new) begin
            r_state  <= w_grant ? ACTIVE : DROP;
            r_to_cnt <= TO_LOAD;
            if (w_grant) r_cur <= w_idx;
         end
      end
   end

   assign sched_busy_mask   = r_busy;
   assign sched_drop_cnt    = r_drop_cnt;
   assign sched_timeout_cnt = r_timeout_cnt;
   assign sched_orphan_cnt  = r_orphan_cnt;

endmodule

// File: tb/tb_rchk_lane_sched.sv
// Self-checking bench for rchk_lane_sched: directed scenarios plus random traffic
// against a packet-level reference model.
module tb_rchk_lane_sched;

   localparam int N    = 4;
   localparam int AW   = 2;
   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          cfg_en;
   logic          rx_pcs_vld;
   logic          rx_pcs_sop_det;
   logic          rx_pcs_term_det;
   logic [N-1:0]  rchk_done;
   logic [N-1:0]  rchk_pkt_vld;
   logic [N-1:0]  rchk_sop;
   logic [N-1:0]  rchk_term;
   logic [AW-1:0] rchk_ln_id;
   logic [N-1:0]  sched_busy_mask;
   logic [CW-1:0] sched_drop_cnt;
   logic [CW-1:0] sched_timeout_cnt;
   logic [CW-1:0] sched_orphan_cnt;

   rchk_lane_sched #(
      .NO_OF_RCHK  (N),
      .TIMEOUT_CYC (TO),
      .CNT_WD      (CW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_en            (cfg_en),
      .rx_pcs_vld        (rx_pcs_vld),
      .rx_pcs_sop_det    (rx_pcs_sop_det),
      .rx_pcs_term_det   (rx_pcs_term_det),
      .rchk_done         (rchk_done),
      .rchk_pkt_vld      (rchk_pkt_vld),
      .rchk_sop          (rchk_sop),
      .rchk_term         (rchk_term),
      .rchk_ln_id        (rchk_ln_id),
      .sched_busy_mask   (sched_busy_mask),
      .sched_drop_cnt    (sched_drop_cnt),
      .sched_timeout_cnt (sched_timeout_cnt),
      .sched_orphan_cnt  (sched_orphan_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_cyc  = 0;

   // Reference model. m_open: -1 no packet, N dropped packet, else owning lane.
   logic [N-1:0] m_busy;
   int           m_ptr;
   int           m_open;
   int           m_age;
   logic [N-1:0] e_vld, e_sop, e_term;
   int           e_ln, e_drop, e_to, e_orph;

   function automatic int sat(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h", tag, n_cyc, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_busy = '0; m_ptr = 0; m_open = -1; m_age = 0;
      e_vld = '0; e_sop = '0; e_term = '0;
      e_ln = 0; e_drop = 0; e_to = 0; e_orph = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] busy0, set_m, clr_m;
      bit           new_sop, new_term;
      int           lane;
      e_vld = '0; e_sop = '0; e_term = '0;
      if (rst) begin
         model_reset();
         return;
      end
      busy0 = m_busy; set_m = '0; clr_m = rchk_done;
      new_sop = 0; new_term = 0;
      if (rx_pcs_vld) begin
         if (m_open < 0) begin
            if (rx_pcs_sop_det) begin
               new_sop  = 1;
               new_term = rx_pcs_term_det;
            end else if (rx_pcs_term_det) begin
               e_orph = sat(e_orph);
            end
         end else if (rx_pcs_term_det) begin
            if (m_open < N) begin e_vld[m_open] = 1'b1; e_term[m_open] = 1'b1; end
            m_open  = -1;
            new_sop = rx_pcs_sop_det;
         end else if (rx_pcs_sop_det) begin
            if (m_open < N) begin e_vld[m_open] = 1'b1; e_sop[m_open] = 1'b1; end
            m_age = 0;
         end else begin
            m_age++;
            if (m_age == TO) begin
               if (m_open < N) clr_m[m_open] = 1'b1;
               e_to   = sat(e_to);
               m_open = -1;
            end else if (m_open < N) begin
               e_vld[m_open] = 1'b1;
            end
         end
         if (new_sop && cfg_en) begin
            lane = -1;
            for (int k = 1; k <= N; k++)
               if (lane < 0 && !busy0[(m_ptr + k) % N]) lane = (m_ptr + k) % N;
            if (lane >= 0) begin
               set_m[lane] = 1'b1;
               m_ptr = lane;
               e_ln  = lane;
               e_vld[lane] = 1'b1;
               e_sop[lane] = 1'b1;
               if (new_term) e_term[lane] = 1'b1;
               else begin m_open = lane; m_age = 0; end
            end else begin
               e_drop = sat(e_drop);
               if (!new_term) begin m_open = N; m_age = 0; end
            end
         end
      end
      m_busy = (busy0 & ~clr_m) | set_m;
   endtask

   task automatic chk_all();
      chk("pkt_vld", 32'(rchk_pkt_vld),      32'(e_vld));
      chk("sop",     32'(rchk_sop),          32'(e_sop));
      chk("term",    32'(rchk_term),         32'(e_term));
      chk("ln_id",   32'(rchk_ln_id),        32'(e_ln));
      chk("busy",    32'(sched_busy_mask),   32'(m_busy));
      chk("drop",    32'(sched_drop_cnt),    32'(e_drop));
      chk("timeout", 32'(sched_timeout_cnt), 32'(e_to));
      chk("orphan",  32'(sched_orphan_cnt),  32'(e_orph));
   endtask

   task automatic cyc(input logic v, input logic s, input logic t,
                      input logic [N-1:0] d, input logic c, input logic r);
      rx_pcs_vld = v; rx_pcs_sop_det = s; rx_pcs_term_det = t;
      rchk_done = d; cfg_en = c; rst = r;
      @(posedge clk);
      model_step();
      #1;
      n_cyc++;
      chk_all();
   endtask

   int exp_ln [4] = '{1, 2, 3, 0};

   initial begin
      rst = 1'b1; cfg_en = 1'b0; rx_pcs_vld = 1'b0;
      rx_pcs_sop_det = 1'b0; rx_pcs_term_det = 1'b0; rchk_done = '0;
      model_reset();

      cyc(0, 0, 0, 4'h0, 1, 1);
      cyc(0, 0, 0, 4'h0, 1, 1);
      chk("dir_rst_vld",  32'(rchk_pkt_vld),    32'h0);
      chk("dir_rst_busy", 32'(sched_busy_mask), 32'h0);

      // four packets fill the pool in round-robin order, fifth is dropped
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 0, 4'h0, 1, 0);
         chk("dir_rr_ln", 32'(rchk_ln_id), 32'(exp_ln[i]));
         cyc(1, 0, 0, 4'h0, 1, 0);
         cyc(1, 0, 1, 4'h0, 1, 0);
      end
      chk("dir_full_busy", 32'(sched_busy_mask), 32'hF);
      cyc(1, 1, 0, 4'h0, 1, 0);
      chk("dir_drop_cnt", 32'(sched_drop_cnt), 32'd1);
      chk("dir_drop_vld", 32'(rchk_pkt_vld),   32'h0);
      cyc(1, 0, 0, 4'h0, 1, 0);
      cyc(1, 0, 1, 4'h0, 1, 0);
      chk("dir_drop_term", 32'(rchk_term), 32'h0);
      cyc(0, 0, 0, 4'hF, 1, 0);
      chk("dir_done_all", 32'(sched_busy_mask), 32'h0);

      // single-beat packet
      cyc(1, 1, 1, 4'h0, 1, 0);
      chk("dir_sb_sop",  32'(rchk_sop),  32'h2);
      chk("dir_sb_term", 32'(rchk_term), 32'h2);
      cyc(0, 0, 0, 4'h2, 1, 0);
      chk("dir_sb_done", 32'(sched_busy_mask), 32'h0);

      // TERM+SOP back to back from lane 1 onto lane 2
      cyc(0, 0, 0, 4'h0, 1, 1);
      cyc(1, 1, 0, 4'h0, 1, 0);
      cyc(1, 0, 0, 4'h0, 1, 0);
      cyc(1, 1, 1, 4'h0, 1, 0);
      chk("dir_b2b_vld",  32'(rchk_pkt_vld), 32'h6);
      chk("dir_b2b_term", 32'(rchk_term),    32'h2);
      chk("dir_b2b_sop",  32'(rchk_sop),     32'h4);
      cyc(1, 0, 0, 4'h0, 1, 0);
      chk("dir_b2b_mid", 32'(rchk_pkt_vld), 32'h4);
      cyc(1, 0, 1, 4'h0, 1, 0);
      chk("dir_b2b_end", 32'(rchk_term), 32'h4);

      // timeout on lane 3, then a stray TERM
      cyc(1, 1, 0, 4'h0, 1, 0);
      chk("dir_to_ln", 32'(rchk_ln_id), 32'd3);
      for (int i = 0; i < TO; i++) cyc(1, 0, 0, 4'h0, 1, 0);
      chk("dir_to_vld",  32'(rchk_pkt_vld),      32'h0);
      chk("dir_to_cnt",  32'(sched_timeout_cnt), 32'd1);
      chk("dir_to_busy", 32'(sched_busy_mask),   32'h6);
      cyc(1, 0, 1, 4'h0, 1, 0);
      chk("dir_orphan", 32'(sched_orphan_cnt), 32'd1);

      // cfg_en gating
      cyc(1, 1, 1, 4'h0, 0, 0);
      chk("dir_cfg_vld",  32'(rchk_pkt_vld),   32'h0);
      chk("dir_cfg_drop", 32'(sched_drop_cnt), 32'd0);
      cyc(1, 1, 0, 4'h0, 1, 0);
      chk("dir_cfg_ln", 32'(rchk_ln_id), 32'd0);
      cyc(1, 0, 0, 4'h0, 0, 0);
      cyc(1, 0, 1, 4'h0, 0, 0);
      chk("dir_cfg_term", 32'(rchk_term), 32'h1);

      // reset while ACTIVE with busy=0011
      cyc(0, 0, 0, 4'h0, 1, 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 4'h0, 1, 0);
      cyc(1, 1, 0, 4'h0, 1, 0);
      cyc(1, 0, 0, 4'hC, 1, 0);
      chk("dir_mr_busy", 32'(sched_busy_mask), 32'h3);
      cyc(1, 0, 0, 4'h0, 1, 1);
      chk("dir_mr_vld",  32'(rchk_pkt_vld),    32'h0);
      chk("dir_mr_bz",   32'(sched_busy_mask), 32'h0);
      cyc(1, 1, 0, 4'h0, 1, 0);
      chk("dir_mr_ln", 32'(rchk_ln_id), 32'd1);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [N-1:0] d;
         for (int b = 0; b < N; b++) d[b] = ($urandom_range(0, 7) == 0);
         cyc($urandom_range(0, 3) != 0,
             $urandom_range(0, 5) == 0,
             (i < 2000) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 14) == 0),
             d,
             $urandom_range(0, 15) != 0,
             $urandom_range(0, 299) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
